// File: rtl/int_controller.sv
// Prioritised, maskable interrupt controller: pending latch per line, fixed priority
// (line 0 highest), req/ack/eoi handshake to the control unit and iMem vector output.

module int_line (
  input  logic clk,
  input  logic rst,
  input  logic irqIn,
  input  logic edgeMode,
  input  logic clr,
  output logic pending
);
  logic prevIrq;

  // A fresh rising edge beats a same-cycle clear; level mode ignores clears entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      prevIrq <= 1'b0;
      pending <= 1'b0;
    end else begin
      prevIrq <= irqIn;
      if (!edgeMode)              pending <= irqIn;
      else if (irqIn && !prevIrq) pending <= 1'b1;
      else if (clr)               pending <= 1'b0;
    end
  end
endmodule

module int_controller #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] VECTOR_BASE  = 16'h0008,
  parameter int          VECTOR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_enable,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata,
  output logic               irq_req,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic [15:0]        vector,
  output logic [2:0]         active_id
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] mask, edgeSel, inService, pending;
  logic [NUM_IRQ-1:0] candidate, selActive, ackClr, swClr;
  logic [NUM_IRQ-1:0] rdSel;
  logic [2:0]         winner;
  logic               ackTaken;

  assign candidate = pending & mask;
  assign ackTaken  = (state == REQ) && irq_ack;
  assign swClr     = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_IRQ-1:0] : '0;
  assign ackClr    = ackTaken ? selActive : '0;

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (candidate[i]) winner = 3'(i);
  end

  always_comb begin
    selActive = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      selActive[i] = (active_id == 3'(i));
  end

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : gLine
      int_line uLine (
        .clk     (clk),
        .rst     (rst),
        .irqIn   (irq_in[g]),
        .edgeMode(edgeSel[g]),
        .clr     (swClr[g] | ackClr[g]),
        .pending (pending[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '0;
      edgeSel <= '1;
    end else if (cfg_we) begin
      if (cfg_addr == 2'd0) mask    <= cfg_wdata[NUM_IRQ-1:0];
      if (cfg_addr == 2'd2) edgeSel <= cfg_wdata[NUM_IRQ-1:0];
    end
  end

  // Single handshake FSM; no nesting, so SERVICE never raises a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_req   <= 1'b0;
      active_id <= '0;
      vector    <= VECTOR_BASE;
      inService <= '0;
    end else begin
      case (state)
        IDLE: if (int_enable && |candidate) begin
          active_id <= winner;
          vector    <= VECTOR_BASE + (16'(winner) << VECTOR_SHIFT);
          irq_req   <= 1'b1;
          state     <= REQ;
        end
        REQ: if (irq_ack) begin
          inService <= inService | selActive;
          irq_req   <= 1'b0;
          state     <= SERVICE;
        end else if (!int_enable || !(|(candidate & selActive))) begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
        SERVICE: if (eoi) begin
          inService <= '0;
          state     <= IDLE;
        end
        default: begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    rdSel = mask;
      2'd1:    rdSel = pending;
      2'd2:    rdSel = edgeSel;
      default: rdSel = inService;
    endcase
    cfg_rdata = 8'(rdSel);
  end
endmodule

// File: tb/tb_int_controller.sv
// Directed-vector bench for int_controller; expected values worked out by hand.

module tb_int_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        int_enable, cfg_we, irq_ack, eoi;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata, cfg_rdata;
  logic        irq_req;
  logic [15:0] vector;
  logic [2:0]  active_id;

  int nChk = 0;
  int nBad = 0;

  int_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .int_enable(int_enable),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_req(irq_req), .irq_ack(irq_ack), .eoi(eoi), .vector(vector), .active_id(active_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChk++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, 16'(cfg_rdata), 16'(exp));
  endtask

  task automatic reqChk(input string tag, input logic [2:0] id, input logic [15:0] vec);
    chk({tag, "_req"}, 16'(irq_req), 16'd1);
    chk({tag, "_id"}, 16'(active_id), 16'(id));
    chk({tag, "_vec"}, vector, vec);
  endtask

  task automatic ackEoi();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic resetChk(input string tag);
    chk({tag, "_req"}, 16'(irq_req), 16'd0);
    chk({tag, "_id"}, 16'(active_id), 16'd0);
    chk({tag, "_vec"}, vector, 16'h0008);
    rd({tag, "_mask"}, 2'd0, 8'h00);
    rd({tag, "_pend"}, 2'd1, 8'h00);
    rd({tag, "_esel"}, 2'd2, 8'hFF);
    rd({tag, "_isvc"}, 2'd3, 8'h00);
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; int_enable = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; irq_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    resetChk("rst");

    // single edge line 2, 2-cycle latency
    wr(2'd0, 8'h04);
    int_enable = 1'b1;
    irq_in = 8'h04; tick(); irq_in = '0;
    chk("t1_lat1", 16'(irq_req), 16'd0);
    tick();
    reqChk("t1", 3'd2, 16'h0010);
    rd("t1_pend", 2'd1, 8'h04);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t1_ackreq", 16'(irq_req), 16'd0);
    rd("t1_pendclr", 2'd1, 8'h00);
    rd("t1_isvc", 2'd3, 8'h04);
    eoi = 1'b1; tick(); eoi = 1'b0;
    rd("t1_isvc0", 2'd3, 8'h00);
    tick();
    chk("t1_idle", 16'(irq_req), 16'd0);

    // priority: lines 5 and 1 together
    wr(2'd0, 8'hFF);
    irq_in = 8'h22; tick(); irq_in = '0; tick();
    reqChk("t2a", 3'd1, 16'h000C);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    rd("t2_pend", 2'd1, 8'h20);
    rd("t2_isvc", 2'd3, 8'h02);
    tick();
    chk("t2_nonest", 16'(irq_req), 16'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_eoi", 16'(irq_req), 16'd0);
    tick();
    reqChk("t2b", 3'd5, 16'h001C);
    ackEoi();

    // withdraw on int_enable drop, then reissue
    irq_in = 8'h08; tick(); irq_in = '0; tick();
    reqChk("t3a", 3'd3, 16'h0014);
    int_enable = 1'b0; tick();
    chk("t3_wdraw", 16'(irq_req), 16'd0);
    rd("t3_pend", 2'd1, 8'h08);
    int_enable = 1'b1; tick();
    reqChk("t3b", 3'd3, 16'h0014);
    ackEoi();

    // level-mode line 0 survives ack and re-requests after eoi
    wr(2'd2, 8'hFE);
    irq_in = 8'h01; tick(); tick();
    reqChk("t4a", 3'd0, 16'h0008);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    rd("t4_pend", 2'd1, 8'h01);
    rd("t4_isvc", 2'd3, 8'h01);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    reqChk("t4b", 3'd0, 16'h0008);
    irq_in = '0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    rd("t4_drop", 2'd1, 8'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    wr(2'd2, 8'hFF);

    // W1C racing a new edge; then clear alone; in_service read-only
    int_enable = 1'b0;
    irq_in = 8'h10; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h10;
    tick(); cfg_we = 1'b0;
    rd("t5_race", 2'd1, 8'h10);
    wr(2'd1, 8'h10);
    rd("t5_clr", 2'd1, 8'h00);
    irq_in = '0;
    wr(2'd3, 8'hFF);
    rd("t5_isvc_ro", 2'd3, 8'h00);

    // reset mid-SERVICE with pending 8'h22
    int_enable = 1'b1;
    irq_in = 8'h22; tick(); irq_in = '0; tick();
    reqChk("t6", 3'd1, 16'h000C);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 8'h02; tick(); irq_in = '0;
    rd("t6_pend", 2'd1, 8'h22);
    rst = 1'b1; tick(); rst = 1'b0;
    resetChk("t6rst");
    wr(2'd0, 8'hFF);
    irq_in = 8'h40; tick(); irq_in = '0; tick();
    reqChk("t6post", 3'd6, 16'h0020);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end
endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Prioritised, maskable interrupt controller for the tinySoC core.
- Latches up to NUM_IRQ peripheral interrupt lines into a pending register and selects the highest-priority enabled line.
- Raises a request/acknowledge handshake to the control unit and supplies the 16-bit instruction-memory vector that the iMem address mux loads on interrupt entry.
- Tracks the in-service line until the control unit signals end-of-interrupt. The core configures and inspects it through a small 8-bit register port on the data-memory/I/O bus.

Parameters:
- NUM_IRQ, 8, number of interrupt lines (1..8); index 0 has highest priority.
- VECTOR_BASE, 16'h0008, iMem address of the vector for line 0.
- VECTOR_SHIFT, 2, log2 of the word spacing between consecutive vectors.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- irq_in, input, NUM_IRQ, peripheral interrupt lines, synchronous to clk.
- int_enable, input, 1, global interrupt-enable bit from the status register.
- cfg_we, input, 1, register write strobe.
- cfg_addr, input, 2, register select: 0 mask, 1 pending, 2 edge_sel, 3 in_service.
- cfg_wdata, input, 8, write data.
- cfg_rdata, output, 8, combinational read data for cfg_addr; bits at or above NUM_IRQ read 0.
- irq_req, output, 1, interrupt request to the control unit.
- irq_ack, input, 1, control unit has taken the interrupt (one-cycle pulse).
- eoi, input, 1, end-of-interrupt pulse (return-from-interrupt executed).
- vector, output, 16, VECTOR_BASE + (active_id << VECTOR_SHIFT).
- active_id, output, 3, index of the line being requested or serviced.

Behaviour:
- Reset: mask=0, pending=0, edge_sel=all ones, in_service=0, prev_irq=0, irq_req=0, active_id=0, vector=VECTOR_BASE, FSM=IDLE.
- Edge mode (edge_sel[i]=1): pending[i] sets on the cycle after irq_in[i] goes 0->1, using the registered prev_irq. It stays set until ack or software clear.
- Level mode (edge_sel[i]=0): pending[i] is registered irq_in[i] each cycle. Ack and software clear have no effect.
- Pending write is write-1-to-clear on edge-mode bits. A new edge in the same cycle as a clear wins, so the bit stays 1.
- Mask and edge_sel writes take effect the next cycle. in_service is read-only and writes to it are ignored.
- Candidate = pending & mask. Winner = lowest set index, chosen by a combinational priority encoder.
- FSM:
  - IDLE: if int_enable=1 and candidate!=0, latch winner into active_id and vector, set irq_req=1, go to REQ. Latency from an irq_in rising edge to irq_req is 2 cycles.
  - REQ: irq_req held at 1 with active_id frozen.
    - On irq_ack: clear pending[active_id] if edge mode, set in_service[active_id], irq_req=0, go to SERVICE.
    - Else if int_enable=0 or pending[active_id]&mask[active_id]=0: irq_req=0, go to IDLE. The request is withdrawn and pending is untouched.
    - If both conditions occur in the same cycle, irq_ack wins.
  - SERVICE: irq_req=0 and no new request is made (no nesting). New pending bits still accumulate. On eoi: in_service=0, go to IDLE. A new request can then be raised on the next cycle.
- irq_ack outside REQ and eoi outside SERVICE are ignored.
- vector and active_id hold their last latched value outside REQ/SERVICE.
- Vector arithmetic is 16-bit unsigned and wraps modulo 2^16.
- rst asserted in any state returns all state to reset values on that edge, including mid-handshake. Pending edges are lost.

Test Plan:
- Reset, mask=8'h04, int_enable=1, pulse irq_in[2] -> irq_req=1 two cycles later, active_id=2, vector=16'h0010. irq_ack -> pending[2]=0, in_service=8'h04. eoi -> in_service=0, FSM IDLE.
- mask=8'hFF, raise irq_in[5] and irq_in[1] in the same cycle -> active_id=1, vector=16'h000C. After ack and eoi, next request has active_id=5, vector=16'h001C.
- In REQ for line 3, deassert int_enable before ack -> irq_req drops next cycle, pending[3] stays 1. Re-enable -> request reissued with active_id=3.
- edge_sel[0]=0, hold irq_in[0]=1 through ack and eoi -> pending[0] remains 1 and a second request is raised after eoi. Drop irq_in -> pending[0]=0 next cycle.
- Write 8'h10 to pending in the same cycle as a new edge on irq_in[4] -> pending[4]=1. Write 8'h10 with no edge -> pending[4]=0.
- Assert rst while in SERVICE with pending=8'h22 -> next cycle all registers are at reset values, irq_req=0, FSM=IDLE, cfg_rdata for addr 2 reads 8'hFF.
